// File: rtl/crc_128_enc_seq.sv
// Multi-cycle CRC-6 (x^6+x+1) encoder: folds a 128-bit word CHUNK_W bits/cycle, emits parity+data codeword.
// Optional error injection on the registered codeword when CRC_ENC_ERRINJ_EN is defined.
module crc_128_enc_seq #(
  parameter int DATA_W  = 128,
  parameter int CRC_W   = 6,
  parameter int CHUNK_W = 8,
  parameter logic [CRC_W:0] POLY = 7'b1000011
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [0:DATA_W-1]         i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [0:DATA_W+CRC_W-1]   o_code,
  output logic                      o_busy
`ifdef CRC_ENC_ERRINJ_EN
  ,
  input  logic                      i_inj_en,
  input  logic [7:0]                i_inj_idx
`endif
);

  localparam int N      = DATA_W / CHUNK_W;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CODE_W = DATA_W + CRC_W;

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t               state, state_nxt;
  logic                 up;
  logic [CRC_W-1:0]     lfsr, lfsr_next;
  logic [CNT_W-1:0]     cnt;
  logic [0:DATA_W-1]    data_q, sh;
  logic [0:CODE_W-1]    code, inj_mask;
  logic                 accept, last;

  assign accept = i_valid && o_ready;
  assign last   = (state == CALC) && (cnt == CNT_W'(N - 1));

  // up keeps o_ready low while in reset and for the edge right after release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      up    <= 1'b0;
    end else begin
      state <= state_nxt;
      up    <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = CALC;
      CALC:    if (last)    state_nxt = OUT;
      OUT:     if (i_ready) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE) && up;
    o_valid = (state == OUT);
    o_busy  = (state != IDLE);
  end

  // sh[0] is the next data bit to fold; the chunk is walked low index first
  always_comb begin
    logic fb;
    fb        = 1'b0;
    lfsr_next = lfsr;
    for (int i = 0; i < CHUNK_W; i++) begin
      fb        = lfsr_next[CRC_W-1] ^ sh[i];
      lfsr_next = {lfsr_next[CRC_W-2:0], 1'b0} ^ (fb ? POLY[CRC_W-1:0] : '0);
    end
  end

`ifdef CRC_ENC_ERRINJ_EN
  logic       inj_en_q;
  logic [7:0] inj_idx_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inj_en_q  <= 1'b0;
      inj_idx_q <= '0;
    end else if (state == IDLE && accept) begin
      inj_en_q  <= i_inj_en;
      inj_idx_q <= i_inj_idx;
    end
  end

  // indices past the codeword match no bit, so they inject nothing
  always_comb begin
    inj_mask = '0;
    for (int j = 0; j < CODE_W; j++)
      if (inj_en_q && inj_idx_q == 8'(j)) inj_mask[j] = 1'b1;
  end
`else
  assign inj_mask = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr   <= '0;
      cnt    <= '0;
      data_q <= '0;
      sh     <= '0;
      code   <= '0;
    end else if (state == IDLE && accept) begin
      data_q <= i_data;
      sh     <= i_data;
      lfsr   <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      lfsr <= lfsr_next;
      sh   <= sh << CHUNK_W;
      cnt  <= cnt + CNT_W'(1);
      if (last) code <= {lfsr_next, data_q} ^ inj_mask;
    end
  end

  assign o_code = code;

endmodule

// File: tb/tb_crc_128_enc_seq.sv
// Directed self-checking bench for crc_128_enc_seq; error-injection cases build when CRC_ENC_ERRINJ_EN is defined.
module tb_crc_128_enc_seq;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [0:127] i_data = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [0:133] o_code;
  logic         o_busy;
`ifdef CRC_ENC_ERRINJ_EN
  logic         i_inj_en = 1'b0;
  logic [7:0]   i_inj_idx = '0;
`endif

  int checks = 0;
  int failures = 0;

  crc_128_enc_seq dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_code(o_code),
    .o_busy(o_busy)
`ifdef CRC_ENC_ERRINJ_EN
    , .i_inj_en(i_inj_en), .i_inj_idx(i_inj_idx)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Parity as a sum of per-bit residues: bit k contributes x^(133-k) mod p, order of x is 63
  function automatic logic [5:0] model_par(input logic [0:127] d);
    logic [5:0] pw [63];
    logic [5:0] acc;
    pw[0] = 6'b000001;
    for (int i = 1; i < 63; i++)
      pw[i] = {pw[i-1][4:0], 1'b0} ^ (pw[i-1][5] ? 6'b000011 : 6'b000000);
    acc = '0;
    for (int k = 0; k < 128; k++)
      if (d[k]) acc ^= pw[(133 - k) % 63];
    return acc;
  endfunction

  task automatic send(input logic [0:127] d, output logic [0:133] code,
                      output int lat, output bit tmo);
    int w;
    tmo = 1'b0; lat = 0; code = '0;
    @(negedge clk);
    i_data = d; i_valid = 1'b1;
    w = 0;
    while (!o_ready && w < 50) begin @(negedge clk); w++; end
    if (!o_ready) begin tmo = 1'b1; i_valid = 1'b0; return; end
    @(posedge clk); #1;
    i_valid = 1'b0;
    while (!o_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    if (!o_valid) begin tmo = 1'b1; return; end
    code = o_code;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++; if (o_code !== 134'h0) begin failures++; $display("FAIL reset_code got=%h exp=0", o_code); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_held got=%b exp=0", o_ready); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL ready_after_release got=%b exp=1", o_ready); end
  endtask

  task automatic test_zero();
    logic [0:133] code; int lat; bit tmo; bit stable;
    send('0, code, lat, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL zero_timeout got=%b exp=0", tmo); end
    checks++; if (lat != 16) begin failures++; $display("FAIL zero_latency got=%0d exp=16", lat); end
    checks++; if (code !== 134'h0) begin failures++; $display("FAIL zero_code got=%h exp=0", code); end
    checks++; if (o_busy !== 1'b1 || o_ready !== 1'b0) begin failures++; $display("FAIL zero_out_flags busy=%b ready=%b exp busy=1 ready=0", o_busy, o_ready); end
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (o_valid !== 1'b1 || o_code !== 134'h0) stable = 1'b0;
    end
    checks++; if (!stable) begin failures++; $display("FAIL zero_stall_stable valid=%b code=%h exp valid=1 code=0", o_valid, o_code); end
    drain();
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      failures++; $display("FAIL zero_release valid=%b ready=%b busy=%b exp 0/1/0", o_valid, o_ready, o_busy); end
  endtask

  task automatic test_single_bit();
    int ks [3] = '{0, 1, 127};
    logic [5:0] ps [3] = '{6'b000110, 6'b000011, 6'b000011};
    logic [0:127] d; logic [0:133] code; logic [0:133] exp; int lat; bit tmo;
    for (int n = 0; n < 3; n++) begin
      d = '0; d[ks[n]] = 1'b1;
      send(d, code, lat, tmo);
      exp = {ps[n], d};
      checks++; if (tmo || code !== exp) begin
        failures++; $display("FAIL single_bit_%0d got=%h exp=%h tmo=%b", ks[n], code, exp, tmo); end
      drain();
    end
  endtask

  task automatic test_linearity();
    logic [0:127] a, b; logic [0:133] ca, cb, cab; int lat; bit t1, t2, t3;
    a = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    b = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
    send(a, ca, lat, t1);      drain();
    send(b, cb, lat, t2);      drain();
    send(a ^ b, cab, lat, t3); drain();
    checks++; if (t1 || ca !== {model_par(a), a}) begin failures++; $display("FAIL lin_a got=%h exp=%h", ca, {model_par(a), a}); end
    checks++; if (t2 || cb !== {model_par(b), b}) begin failures++; $display("FAIL lin_b got=%h exp=%h", cb, {model_par(b), b}); end
    checks++; if (t3 || cab[6:133] !== (a ^ b)) begin failures++; $display("FAIL lin_data got=%h exp=%h", cab[6:133], a ^ b); end
    checks++; if ((ca[0:5] ^ cb[0:5]) !== cab[0:5]) begin
      failures++; $display("FAIL lin_xor got=%b exp=%b", cab[0:5], ca[0:5] ^ cb[0:5]); end
  endtask

  task automatic test_random();
    logic [0:127] d; logic [0:133] code; int lat; bit tmo;
    for (int n = 0; n < 16; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, code, lat, tmo);
      checks++; if (tmo || lat != 16 || code !== {model_par(d), d}) begin
        failures++; $display("FAIL random_%0d got=%h exp=%h lat=%0d", n, code, {model_par(d), d}, lat); end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int rise [4]; int nr; bit prev;
    nr = 0; prev = 1'b0;
    @(negedge clk);
    i_data = 128'h5; i_valid = 1'b1; i_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (o_valid && !prev && nr < 4) begin rise[nr] = c; nr++; end
      prev = o_valid;
    end
    i_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1; i_ready = 1'b0;
    checks++; if (nr < 2) begin failures++; $display("FAIL b2b_rises got=%0d exp>=2", nr); end
    else begin
      checks++; if (rise[1] - rise[0] != 18) begin
        failures++; $display("FAIL b2b_interval got=%0d exp=18", rise[1] - rise[0]); end
    end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle busy=%b exp=0", o_busy); end
  endtask

  task automatic test_reset_mid_calc();
    logic [0:127] b; logic [0:133] code; int lat; bit tmo; bit seen;
    @(negedge clk);
    i_data = 128'hFFFF_0000_1234_5678_9ABC_DEF0_0F0F_F0F0; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0 || o_code !== 134'h0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
      failures++; $display("FAIL midcalc_reset valid=%b busy=%b ready=%b code=%h exp all 0", o_valid, o_busy, o_ready, o_code); end
    @(negedge clk); reset_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (o_valid) seen = 1'b1; end
    checks++; if (seen) begin failures++; $display("FAIL midcalc_no_valid got=1 exp=0"); end
    b = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    send(b, code, lat, tmo);
    checks++; if (tmo || code !== {model_par(b), b}) begin
      failures++; $display("FAIL midcalc_next got=%h exp=%h", code, {model_par(b), b}); end
    drain();
  endtask

`ifdef CRC_ENC_ERRINJ_EN
  task automatic test_errinj();
    logic [0:133] code; logic [0:133] exp; logic [0:127] a; int lat; bit tmo;
    i_inj_en = 1'b1; i_inj_idx = 8'd6;
    send('0, code, lat, tmo); drain();
    exp = '0; exp[6] = 1'b1;
    checks++; if (tmo || code !== exp) begin failures++; $display("FAIL inj_idx6 got=%h exp=%h", code, exp); end
    i_inj_idx = 8'd200;
    send('0, code, lat, tmo); drain();
    checks++; if (tmo || code !== 134'h0) begin failures++; $display("FAIL inj_idx200 got=%h exp=0", code); end
    a = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    i_inj_idx = 8'd0;
    send(a, code, lat, tmo); drain();
    exp = {model_par(a), a}; exp[0] = ~exp[0];
    checks++; if (tmo || code !== exp) begin failures++; $display("FAIL inj_idx0 got=%h exp=%h", code, exp); end
    i_inj_en = 1'b0;
    send(a, code, lat, tmo); drain();
    checks++; if (tmo || code !== {model_par(a), a}) begin failures++; $display("FAIL inj_off got=%h exp=%h", code, {model_par(a), a}); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_single_bit();
    test_linearity();
    test_random();
    test_back_to_back();
    test_reset_mid_calc();
`ifdef CRC_ENC_ERRINJ_EN
    test_errinj();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
